// File: rtl/lstm_pkg.sv
// lstm_pkg: shared constants for the LSTM sequencer slice.
//   WIDTH/FRAC  : Q6.11 word format
//   NUM_WT      : gate weight/bias count held by the controller
//   WI_*        : weight bank index per gate term (same order as wr_addr)
//   st_e        : sequencer FSM states
package lstm_pkg;
  localparam int WIDTH  = 18;
  localparam int FRAC   = 11;
  localparam int NUM_WT = 12;

  localparam logic [3:0] WI_FX = 4'd0,  WI_FH = 4'd1,  WI_BF = 4'd2;
  localparam logic [3:0] WI_IX = 4'd3,  WI_IH = 4'd4,  WI_BI = 4'd5;
  localparam logic [3:0] WI_GX = 4'd6,  WI_GH = 4'd7,  WI_BG = 4'd8;
  localparam logic [3:0] WI_OX = 4'd9,  WI_OH = 4'd10, WI_BO = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPT, ST_OUT} st_e;
endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// lstm_seq_ctrl_if: sample stream in (s_*), h_t stream out (m_*) and the
// weight write port (wr_*) of the sequencer.
//   slave  : the sequencer side
//   master : the source/sink/host side
interface lstm_seq_ctrl_if #(parameter int WIDTH = lstm_pkg::WIDTH);
  logic             s_valid, s_ready, s_last;
  logic [WIDTH-1:0] s_data;
  logic             m_valid, m_ready, m_last;
  logic [WIDTH-1:0] m_data;
  logic             wr_en, wr_err;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport slave (
    input  s_valid, s_data, s_last, m_ready, wr_en, wr_addr, wr_data,
    output s_ready, m_valid, m_data, m_last, wr_err
  );
  modport master (
    output s_valid, s_data, s_last, m_ready, wr_en, wr_addr, wr_data,
    input  s_ready, m_valid, m_data, m_last, wr_err
  );
endinterface

// File: rtl/lstm_wt_bank.sv
// lstm_wt_bank: 12 x WIDTH gate weight/bias registers.
//   idle     in  : writes land only while the sequencer is idle
//   wr_*     in  : write strobe/address/data
//   wr_err   out : 1-cycle pulse when a write is dropped (busy or addr>11)
//   cell_wt  out : packed bank, entry k at [k*WIDTH +: WIDTH]
module lstm_wt_bank
  import lstm_pkg::*;
#(
  parameter int WIDTH = lstm_pkg::WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    idle,
  input  logic                    wr_en,
  input  logic [3:0]              wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    wr_err,
  output logic [NUM_WT*WIDTH-1:0] cell_wt
);
  logic [NUM_WT-1:0][WIDTH-1:0] wt_q;
  logic                         addr_ok, wr_ok;

  assign addr_ok = (wr_addr < 4'(NUM_WT));
  assign wr_ok   = wr_en && idle && addr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_q   <= '0;
      wr_err <= 1'b0;
    end else begin
      if (wr_ok) wt_q[wr_addr] <= wr_data;
      wr_err <= wr_en && !wr_ok;
    end
  end

  assign cell_wt = wt_q;
endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps one external LSTM cell over a sample stream.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : s_* sample in, m_* h_t out, wr_* weight writes
//   cell_x_t/c_prev/h_prev/cell_wt out : cell operands
//   cell_c_t/h_t    in  : cell registered results
//   busy            : FSM not idle
//   step_cnt        : steps done in current sequence (saturating)
// Build option LSTM_STATE_SAT_EN: clamp stored c to [-SAT_LIM, +SAT_LIM].
// One sample in flight: IDLE -> ISSUE -> CAPT -> OUT.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH   = lstm_pkg::WIDTH,
  parameter int FRAC    = lstm_pkg::FRAC,
  parameter int CNT_W   = 16,
  parameter int SAT_LIM = 8191
) (
  input  logic                    clk,
  input  logic                    rst_n,
  lstm_seq_ctrl_if.slave          bus,
  output logic [WIDTH-1:0]        cell_x_t,
  output logic [WIDTH-1:0]        cell_c_prev,
  output logic [WIDTH-1:0]        cell_h_prev,
  output logic [NUM_WT*WIDTH-1:0] cell_wt,
  input  logic [WIDTH-1:0]        cell_c_t,
  input  logic [WIDTH-1:0]        cell_h_t,
  output logic                    busy,
  output logic [CNT_W-1:0]        step_cnt
);
  st_e              state, state_d;
  logic [WIDTH-1:0] x_q, c_st, h_st, c_nxt, m_data_q;
  logic             last_q, m_valid_q, m_last_q;

  lstm_wt_bank #(.WIDTH(WIDTH)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .idle    (state == ST_IDLE),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .wr_err  (bus.wr_err),
    .cell_wt (cell_wt)
  );

`ifdef LSTM_STATE_SAT_EN
  localparam logic signed [WIDTH-1:0] C_HI = WIDTH'(SAT_LIM);
  localparam logic signed [WIDTH-1:0] C_LO = -C_HI;
  always_comb begin
    c_nxt = cell_c_t;
    if ($signed(cell_c_t) > C_HI)      c_nxt = C_HI;
    else if ($signed(cell_c_t) < C_LO) c_nxt = C_LO;
  end
`else
  assign c_nxt = cell_c_t;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (bus.s_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_CAPT;   // cell samples operands at end of this cycle
      ST_CAPT:  state_d = ST_OUT;
      ST_OUT:   if (bus.m_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      last_q    <= 1'b0;
      c_st      <= '0;
      h_st      <= '0;
      step_cnt  <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.s_valid) begin
          x_q    <= bus.s_data;
          last_q <= bus.s_last;
        end
        ST_CAPT: begin
          c_st      <= c_nxt;
          h_st      <= cell_h_t;
          m_data_q  <= cell_h_t;
          m_last_q  <= last_q;
          m_valid_q <= 1'b1;
          if (step_cnt != '1) step_cnt <= step_cnt + 1'b1;
        end
        ST_OUT: if (bus.m_ready) begin
          m_valid_q <= 1'b0;
          // sequence end: next sample starts from zero state
          if (m_last_q) begin
            c_st     <= '0;
            h_st     <= '0;
            step_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign cell_x_t    = x_q;
  assign cell_c_prev = c_st;
  assign cell_h_prev = h_st;
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Bench for lstm_seq_ctrl. A small registered stand-in cell sits behind the
// controller: c_t = c_prev + x_t + b_f, h_t = h_prev + x_t + b_o (18-bit wrap),
// so the state chain is fully predictable from the bench's own model.
module tb_lstm_seq_ctrl;
  localparam int W = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lstm_seq_ctrl_if #(.WIDTH(W)) bus();

  logic [W-1:0]    cell_x_t, cell_c_prev, cell_h_prev, cell_c_t, cell_h_t;
  logic [12*W-1:0] cell_wt;
  logic            busy;
  logic [15:0]     step_cnt;

  lstm_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cell_x_t    (cell_x_t),
    .cell_c_prev (cell_c_prev),
    .cell_h_prev (cell_h_prev),
    .cell_wt     (cell_wt),
    .cell_c_t    (cell_c_t),
    .cell_h_t    (cell_h_t),
    .busy        (busy),
    .step_cnt    (step_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_c_t <= '0;
      cell_h_t <= '0;
    end else begin
      cell_c_t <= cell_c_prev + cell_x_t + cell_wt[2*W +: W];
      cell_h_t <= cell_h_prev + cell_x_t + cell_wt[11*W +: W];
    end
  end

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] c;
    logic         last;
    logic [15:0]  cnt;
  } exp_t;
  exp_t sbq[$];

  logic [W-1:0] m_c, m_h, wt_bf, wt_bo;
  logic [15:0]  m_cnt;
  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [12*W-1:0] exp_wt();
    logic [12*W-1:0] v;
    v = '0;
    v[2*W +: W]  = wt_bf;
    v[11*W +: W] = wt_bo;
    return v;
  endfunction

  task automatic model_clear();
    m_c = '0; m_h = '0; m_cnt = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk("wr_err_idle", bus.wr_err, 0);
    if (a == 4'd2)  wt_bf = d;
    if (a == 4'd11) wt_bo = d;
    chk("wt_bank", cell_wt == exp_wt(), 1);
  endtask

  // returns #1 after the accepting edge (controller now in ISSUE)
  task automatic send(input logic [W-1:0] x, input logic l, input logic dow = 1'b0,
                      input logic [3:0] wa = 4'd0, input logic [W-1:0] wd = '0);
    int n;
    logic [W-1:0] nc;
    exp_t e;
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = x; bus.s_last = l;
    if (dow) begin bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd; end
    n = 0;
    while (!bus.s_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.s_ready) begin
      chk("accept_timeout", 1, 0);
      bus.s_valid = 1'b0; bus.wr_en = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0; bus.wr_en = 1'b0;
    if (dow && wa == 4'd2)  wt_bf = wd;
    if (dow && wa == 4'd11) wt_bo = wd;
    nc = m_c + x + wt_bf;
`ifdef LSTM_STATE_SAT_EN
    if ($signed(nc) > 18'sd8191)       nc = 18'sd8191;
    else if ($signed(nc) < -18'sd8191) nc = -18'sd8191;
`endif
    m_c = nc;
    m_h = m_h + x + wt_bo;
    if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
    e.h = m_h; e.c = m_c; e.last = l; e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic recv(input int hold);
    exp_t e;
    int n;
    logic [W-1:0] d0;
    n = 0;
    while (!bus.m_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.m_valid) begin chk("out_timeout", 0, 1); return; end
    if (sbq.size() == 0) begin chk("sb_empty", 1, 0); return; end
    e = sbq.pop_front();
    chk("m_data", bus.m_data, e.h);
    chk("m_last", bus.m_last, e.last);
    chk("step_cnt", step_cnt, e.cnt);
    chk("c_st", cell_c_prev, e.c);
    chk("h_st", cell_h_prev, e.h);
    d0 = bus.m_data;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_data", bus.m_data, d0);
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_sready", bus.s_ready, 0);
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    chk("post_valid", bus.m_valid, 0);
    chk("post_idle", busy, 0);
    if (e.last) begin
      model_clear();
      chk("seq_end_cnt", step_cnt, 0);
      chk("seq_end_c", cell_c_prev, 0);
      chk("seq_end_h", cell_h_prev, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    wt_bf = '0; wt_bo = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_wt", cell_wt == '0, 1);

    // single-step sequence and output latency
    send(18'h00800, 1'b1);
    chk("lat_issue", bus.m_valid, 0);
    chk("lat_sready", bus.s_ready, 0);
    @(posedge clk); #1;
    chk("lat_capt", bus.m_valid, 0);
    @(posedge clk); #1;
    chk("lat_out", bus.m_valid, 1);
    recv(0);

    // 3-step chained sequence
    send(18'h00400, 1'b0); recv(0);
    send(18'h3fc00, 1'b0); recv(0);
    send(18'h00123, 1'b1); recv(0);

    // downstream backpressure
    send(18'h00555, 1'b1); recv(10);

    // nonzero biases, then a write coincident with an accept
    wr(4'd2, 18'd5);
    wr(4'd11, 18'h3fffd);
    send(18'h00010, 1'b0); recv(0);
    send(18'h00020, 1'b1, 1'b1, 4'd2, 18'd100); recv(0);

    // write while busy
    send(18'h00033, 1'b1);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 18'd77;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk("wr_err_busy", bus.wr_err, 1);
    chk("wt_busy_unchanged", cell_wt == exp_wt(), 1);
    @(posedge clk); #1;
    chk("wr_err_pulse", bus.wr_err, 0);
    recv(0);

    // out-of-range address
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd13; bus.wr_data = 18'd99;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    chk("wr_err_addr", bus.wr_err, 1);
    chk("wt_addr_unchanged", cell_wt == exp_wt(), 1);
    @(posedge clk); #1;
    chk("wr_err_addr_pulse", bus.wr_err, 0);

    // reset during CAPT
    send(18'h00100, 1'b0); recv(0);
    send(18'h00200, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_c", cell_c_prev, 0);
    chk("mid_rst_h", cell_h_prev, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wt", cell_wt == '0, 1);
    sbq.delete();
    model_clear();
    wt_bf = '0; wt_bo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send(18'h00300, 1'b1); recv(0);

    // large cell state: clamped only with the saturation build
    send(18'd12000, 1'b1); recv(0);

    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
